// File: rtl/pc_unit.sv
// Program counter unit: next-PC select, exception entry/return, optional RAS.
// Build with PC_UNIT_RAS_EN defined to include the return-address stack.
module pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        exc_req,
    input  logic [2:0]  npc_op,
    input  logic [25:0] imm,
    input  logic [31:0] rd1,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause,
    output logic        ras_miss,
    output logic [4:0]  ras_cnt
);

    typedef enum logic [2:0] {
        OP_PLUS4  = 3'b000,
        OP_BRANCH = 3'b001,
        OP_JUMP   = 3'b010,
        OP_JR     = 3'b011,
        OP_JAL    = 3'b100,
        OP_JALR   = 3'b101,
        OP_ERET   = 3'b110,
        OP_RSVD   = 3'b111
    } npc_op_e;

    npc_op_e     op;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        is_reg_jmp;
    logic        misal;

    assign op         = npc_op_e'(npc_op);
    assign pc_plus4   = pc_q + 32'd4;
    assign br_tgt     = pc_plus4 + {{14{imm[15]}}, imm[15:0], 2'b00};
    assign j_tgt      = {pc_plus4[31:28], imm, 2'b00};
    assign is_reg_jmp = (op == OP_JR) || (op == OP_JALR);
    assign misal      = is_reg_jmp && (rd1[1:0] != 2'b00);

    // Next-PC selection: exception, misaligned target, stall, then opcode
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        if (exc_req) begin
            pc_d    = EXC_VEC;
            epc_d   = pc_q;
            cause_d = 2'b01;
        end else if (!stall && misal) begin
            pc_d    = EXC_VEC;
            epc_d   = pc_q;
            cause_d = 2'b10;
        end else if (!stall) begin
            unique case (op)
                OP_BRANCH: pc_d = br_tgt;
                OP_JUMP:   pc_d = j_tgt;
                OP_JAL:    pc_d = j_tgt;
                OP_JR:     pc_d = rd1;
                OP_JALR:   pc_d = rd1;
                OP_ERET: begin
                    pc_d    = epc_q;
                    cause_d = 2'b00;
                end
                OP_PLUS4:  pc_d = pc_plus4;
                OP_RSVD:   pc_d = pc_plus4;
            endcase
        end
    end

    // PC, EPC and cause registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            cause_q <= 2'b00;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign exc_cause = cause_q;

`ifdef PC_UNIT_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_MAX = PW'(RAS_DEPTH - 1);
    localparam logic [4:0]    CNT_MAX = 5'(RAS_DEPTH);

    logic [31:0]   ras_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] top;
    logic [4:0]    cnt_q, cnt_d;
    logic          miss_q, miss_d;
    logic          ctl_en;
    logic          push;
    logic          pop;

    assign ctl_en = !exc_req && !stall && !misal;
    assign push   = ctl_en && ((op == OP_JAL) || (op == OP_JALR));
    assign pop    = ctl_en && (op == OP_JR);
    assign top    = (ptr_q == '0) ? PTR_MAX : ptr_q - 1'b1;

    // Circular stack: ptr is the next write slot; full pushes drop the oldest
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        miss_d = 1'b0;
        if (push) begin
            ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
        end else if (pop) begin
            if (cnt_q == 5'd0) begin
                miss_d = 1'b1;
            end else begin
                miss_d = (ras_q[top] != rd1);
                ptr_d  = top;
                cnt_d  = cnt_q - 5'd1;
            end
        end
    end

    // Stack pointer, occupancy and miss pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q  <= '0;
            cnt_q  <= 5'd0;
            miss_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            miss_q <= miss_d;
        end
    end

    // Stack storage; contents are meaningless until counted valid
    always_ff @(posedge clk) begin
        if (rstn && push) ras_q[ptr_q] <= pc_plus4;
    end

    assign ras_miss = miss_q;
    assign ras_cnt  = cnt_q;
`else
    assign ras_miss = 1'b0;
    assign ras_cnt  = 5'(RAS_DEPTH) & 5'd0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a queued scoreboard and
// an independent per-cycle monitor.
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
    localparam int RAS_ON = 1;
`else
    localparam int RAS_ON = 0;
`endif

    localparam logic [2:0] PLUS4  = 3'b000;
    localparam logic [2:0] BRANCH = 3'b001;
    localparam logic [2:0] JUMP   = 3'b010;
    localparam logic [2:0] JR     = 3'b011;
    localparam logic [2:0] JAL    = 3'b100;
    localparam logic [2:0] JALR   = 3'b101;
    localparam logic [2:0] ERET   = 3'b110;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        exc_req = 1'b0;
    logic [2:0]  npc_op = 3'b000;
    logic [25:0] imm = '0;
    logic [31:0] rd1 = '0;
    logic [31:0] pc, pc_plus4, epc;
    logic [1:0]  exc_cause;
    logic        ras_miss;
    logic [4:0]  ras_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic        miss;
        logic [4:0]  cnt;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   stim_done = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk),
        .rstn(rstn),
        .stall(stall),
        .exc_req(exc_req),
        .npc_op(npc_op),
        .imm(imm),
        .rd1(rd1),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .epc(epc),
        .exc_cause(exc_cause),
        .ras_miss(ras_miss),
        .ras_cnt(ras_cnt)
    );

    task automatic chk(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
        end
    endtask

    task automatic step(input logic rn, input logic [2:0] op,
                        input logic [25:0] im, input logic [31:0] r,
                        input logic st, input logic ex,
                        input logic [31:0] xpc, input logic [31:0] xepc,
                        input logic [1:0] xc, input int xm, input int xn,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rstn    = rn;
        npc_op  = op;
        imm     = im;
        rd1     = r;
        stall   = st;
        exc_req = ex;
        e.pc    = xpc;
        e.epc   = xepc;
        e.cause = xc;
        e.miss  = 1'(xm * RAS_ON);
        e.cnt   = 5'(xn * RAS_ON);
        e.name  = nm;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "pc", pc, e.pc);
                chk(e.name, "pc4", pc_plus4, e.pc + 32'd4);
                chk(e.name, "epc", epc, e.epc);
                chk(e.name, "cause", 32'(exc_cause), 32'(e.cause));
                chk(e.name, "miss", 32'(ras_miss), 32'(e.miss));
                chk(e.name, "cnt", 32'(ras_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin : stim
        step(0, PLUS4, 0, 0, 0, 0, 32'h3000, 0, 0, 0, 0, "rst0");
        step(0, JUMP, 26'h40, 0, 0, 0, 32'h3000, 0, 0, 0, 0, "rst1");
        step(1, PLUS4, 0, 0, 0, 0, 32'h3004, 0, 0, 0, 0, "p4a");
        step(1, PLUS4, 0, 0, 0, 0, 32'h3008, 0, 0, 0, 0, "p4b");
        step(1, PLUS4, 0, 0, 0, 0, 32'h300C, 0, 0, 0, 0, "p4c");
        step(1, PLUS4, 0, 0, 0, 0, 32'h3010, 0, 0, 0, 0, "p4d");
        step(1, BRANCH, 26'hFFFC, 0, 0, 0,
             32'h3004, 0, 0, 0, 0, "brneg");
        step(1, JUMP, 26'hC40, 0, 0, 0, 32'h3100, 0, 0, 0, 0, "jump");
        step(1, JUMP, 26'h40, 0, 1, 0, 32'h3100, 0, 0, 0, 0, "stall");
        step(1, BRANCH, 26'h0010, 0, 0, 0,
             32'h3144, 0, 0, 0, 0, "brpos");
        step(1, JUMP, 26'hC08, 0, 0, 0, 32'h3020, 0, 0, 0, 0, "j3020");
        step(1, PLUS4, 0, 0, 1, 1, 32'h4180, 32'h3020, 1, 0, 0, "excst");
        step(1, ERET, 0, 0, 0, 0, 32'h3020, 32'h3020, 0, 0, 0, "eret1");
        step(1, JR, 0, 32'h3002, 0, 0,
             32'h4180, 32'h3020, 2, 0, 0, "misal");
        step(1, PLUS4, 0, 0, 1, 0, 32'h4180, 32'h3020, 2, 0, 0, "sticky");
        step(1, ERET, 0, 0, 0, 0, 32'h3020, 32'h3020, 0, 0, 0, "eret2");
        step(1, JUMP, 26'hC00, 0, 0, 0, 32'h3000, 32'h3020, 0, 0, 0, "j3000");
        step(1, JAL, 26'hC40, 0, 0, 0, 32'h3100, 32'h3020, 0, 0, 1, "jal1");
        step(1, JAL, 26'hC80, 0, 0, 0, 32'h3200, 32'h3020, 0, 0, 2, "jal2");
        step(1, JAL, 26'hCC0, 0, 0, 0, 32'h3300, 32'h3020, 0, 0, 3, "jal3");
        step(1, JAL, 26'hD00, 0, 0, 0, 32'h3400, 32'h3020, 0, 0, 4, "jal4");
        step(1, JAL, 26'hD40, 0, 0, 0, 32'h3500, 32'h3020, 0, 0, 4, "jal5");
        step(1, JR, 0, 32'h3404, 1, 0, 32'h3500, 32'h3020, 0, 0, 4, "jrst");
        step(1, JR, 0, 32'h3404, 0, 0, 32'h3404, 32'h3020, 0, 0, 3, "jr1");
        step(1, JR, 0, 32'h3304, 0, 0, 32'h3304, 32'h3020, 0, 0, 2, "jr2");
        step(1, JR, 0, 32'h3204, 0, 0, 32'h3204, 32'h3020, 0, 0, 1, "jr3");
        step(1, JR, 0, 32'h3104, 0, 0, 32'h3104, 32'h3020, 0, 0, 0, "jr4");
        step(1, JR, 0, 32'h3000, 0, 0, 32'h3000, 32'h3020, 0, 1, 0, "jrmt");
        step(1, PLUS4, 0, 0, 0, 0, 32'h3004, 32'h3020, 0, 0, 0, "pulse");
        step(1, JALR, 0, 32'h3100, 0, 0, 32'h3100, 32'h3020, 0, 0, 1, "jalr");
        step(1, JAL, 26'hC80, 0, 0, 1, 32'h4180, 32'h3100, 1, 0, 1, "excjal");
        step(1, JR, 0, 32'h3200, 0, 0, 32'h3200, 32'h3100, 1, 1, 0, "jrbad");
        step(1, JALR, 0, 32'h3001, 0, 0, 32'h4180, 32'h3200, 2, 0, 0, "jalrmis");
        step(1, ERET, 0, 0, 0, 0, 32'h3200, 32'h3200, 0, 0, 0, "eret3");
        step(1, 3'b111, 0, 0, 0, 0, 32'h3204, 32'h3200, 0, 0, 0, "rsvd");
        step(0, JUMP, 26'hD00, 0, 0, 0, 32'h3000, 0, 0, 0, 0, "midrst");
        step(1, PLUS4, 0, 0, 0, 0, 32'h3004, 0, 0, 0, 0, "post");
        stim_done = 1;
    end

    initial begin : finisher
        wait (stim_done);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset.
REQ-002 Parameter EXC_VEC, default 32'h0000_4180: PC value loaded on an exception.
REQ-003 Parameter RAS_DEPTH, default 4, legal 2..16: return-address-stack entries.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- stall  in  1  hold all state this cycle.
- exc_req  in  1  external exception request.
- npc_op  in  3  000 PLUS4, 001 BRANCH, 010 JUMP, 011 JR, 100 JAL, 101 JALR, 110 ERET, 111 reserved (treated as PLUS4).
- imm  in  26  jump index; [15:0] is the branch offset.
- rd1  in  32  register target for JR/JALR.
- pc  out  32  current PC (registered).
- pc_plus4  out  32  pc+4, combinational link address.
- epc  out  32  exception return PC (registered).
- exc_cause  out  2  00 none, 01 external, 10 misaligned target (registered, sticky until next exception or ERET).
- ras_miss  out  1  one-cycle registered pulse on a return misprediction.
- ras_cnt  out  5  valid RAS entries.

Function
REQ-005 Targets: BRANCH = pc+4+sext({imm[15:0],2'b00}); JUMP/JAL = {pc_plus4[31:28],imm,2'b00}; JR/JALR = rd1; ERET = epc; all arithmetic is modulo 2^32.
REQ-006 Update priority per rising edge: exc_req, then misaligned JR/JALR (rd1[1:0]!=0), then stall, then npc_op.
REQ-007 exc_req=1 (even while stall=1): pc<=EXC_VEC; epc<=pc; exc_cause<=01; RAS unchanged.
REQ-008 JR/JALR with rd1[1:0]!=0 and stall=0: pc<=EXC_VEC; epc<=pc; exc_cause<=10; no push or pop.
REQ-009 stall=1 with no exception: pc, epc, exc_cause, RAS and ras_cnt hold; ras_miss<=0.
REQ-010 Otherwise pc<=target, one-cycle latency; ERET additionally sets exc_cause<=00.
REQ-011 JAL and JALR push pc+4 onto the RAS.
- Full stack: the push overwrites the oldest entry (circular) and ras_cnt stays at RAS_DEPTH.
REQ-012 JR pops the RAS; ras_miss<=1 if the stack is empty or the popped value != rd1, else 0.
- Empty stack: the pop leaves ras_cnt at 0.
REQ-013 JALR does not pop; PLUS4, BRANCH, JUMP and ERET leave the RAS untouched.
REQ-014 ras_miss is 0 on every cycle not in which a JR completes.

Reset
REQ-015 rstn=0 asynchronously sets pc=RESET_PC, epc=0, exc_cause=00, ras_miss=0, ras_cnt=0, and clears the RAS pointer.
REQ-016 Reset asserted mid-operation discards any pending update.
REQ-017 The first update after rstn deasserts occurs on the first rising edge with rstn=1.

Configuration
REQ-018 Macro PC_UNIT_RAS_EN defined: RAS behaviour per REQ-011..014.
REQ-019 Macro PC_UNIT_RAS_EN undefined: no RAS storage is built; ras_miss and ras_cnt are tied 0; JAL/JALR/JR update pc identically otherwise.

Verification
REQ-020 Reset, then 3 cycles of PLUS4 -> pc = 3000, 3004, 3008, 300C.
REQ-021 Branch and jump:
- pc=3010, BRANCH, imm=16'hFFFC -> pc=3004.
- JUMP, imm=26'h0000C40 -> pc=3100.
REQ-022 Exception while stalled: pc=3020, stall=1, exc_req=1 -> pc=4180, epc=3020, exc_cause=01; then ERET -> pc=3020, exc_cause=00.
REQ-023 JR with rd1=32'h0000_3002 -> pc=4180, exc_cause=10, ras_cnt unchanged.
REQ-024 RAS (macro defined):
- 5 JALs from pc 3000, 3100, 3200, 3300, 3400 -> ras_cnt=4.
- Then JR rd1=3404 -> ras_miss=0.
- Then three JRs with matching values, then a 4th JR -> ras_miss=1 (empty).
REQ-025 Macro undefined: repeat the REQ-024 stimulus -> identical pc trace, ras_miss=0 and ras_cnt=0 throughout.
